serial_slice_adder_ctrl: RTL and testbench
==========================================

// Module: serial_slice_adder_ctrl
// PURPOSE
//  Sequencer that produces a WIDTH-bit sum by reusing one SLICE-bit adder slice.
//  The slice computes {co, s} = a + b + ci and is used in full_adder4 fashion.
//  The block steps the slice over the operand from LSB to MSB, one slice per cycle.
//  The slice carry is registered between steps.
//  Sits between an operand producer and a result consumer.
//  Both sides use valid/ready handshakes.
//  Trades latency for area against a full-width ripple adder.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; must be a multiple of SLICE
//  SLICE  4   bits added per cycle; width of the shared adder slice
//  N = WIDTH/SLICE (derived)  number of slice steps per operation
// PORTS
//  clk_i      in   1      clock; all state updates on rising edge
//  rst_ni     in   1      asynchronous reset, active low
//  start_i    in   1      operand valid from producer
//  ready_o    out  1      block can accept operands (IDLE only)
//  a_i        in   WIDTH  operand A, sampled on accept
//  b_i        in   WIDTH  operand B, sampled on accept
//  carry_i    in   1      carry-in into slice 0, sampled on accept
//  valid_o    out  1      result valid to consumer
//  ready_i    in   1      consumer accepts result
//  sum_o      out  WIDTH  registered sum
//  carry_o    out  1      carry out of the MSB slice
//  busy_o     out  1      high in RUN or DONE
// BEHAVIOUR
//  Reset state while rst_ni=0, applied asynchronously:
//  - FSM=IDLE, ready_o=1, valid_o=0, busy_o=0.
//  - sum_o=0, carry_o=0, slice index=0, carry register=0.
//  FSM states: IDLE, RUN, DONE.
//  IDLE:
//  - ready_o=1.
//  - On start_i&&ready_o: latch a_i, b_i, carry_i into carry register; index=0; go RUN.
//  RUN, one slice per cycle:
//  - Slice k adds a[k*SLICE +: SLICE] + b[...] + carry register.
//  - The result writes sum_o[k*SLICE +: SLICE]; carry register takes the slice carry out.
//  - Index increments each cycle.
//  - On the edge that finishes slice N-1: carry_o = final carry; go DONE.
//  - Index counter width is clog2(N), minimum 1. No wrap-around; the counter reloads to 0 on accept.
//  DONE:
//  - valid_o=1; sum_o and carry_o are held stable.
//  - On valid_o&&ready_i: go IDLE. valid_o drops on the next cycle.
//  - ready_i low holds DONE for any number of cycles; results stay unchanged.
//  Latency:
//  - Accept edge at cycle 0; valid_o is high from cycle N+1 (N RUN cycles).
//  - WIDTH=32, SLICE=4: valid_o rises 9 cycles after the accept edge.
//  - Minimum issue interval is N+2 cycles (RUN x N, DONE x1, IDLE x1).
//  Boundary conditions:
//  - start_i while busy: ignored, ready_o=0; operands not sampled; no queueing.
//  - a_i/b_i/carry_i changing after accept: no effect on the operation in flight.
//  - ready_i high outside DONE: ignored.
//  - WIDTH==SLICE (N=1): one RUN cycle, then DONE.
//  - WIDTH%SLICE!=0 or SLICE<1: elaboration-time error ($error in generate).
//  - Reset mid-RUN/DONE: immediate abort to reset state; the partial sum is discarded.
//  - sum_o during RUN is partial and not valid; consumers use it only when valid_o=1.
//  Arithmetic: unsigned modulo 2^WIDTH; carry_o is bit WIDTH of a+b+carry_i.
// TESTING
//  1. 0xFFFFFFFF+0x00000001, carry_i=0, ready_i=1 -> sum_o=0x00000000, carry_o=1.
//     valid_o is high in cycle 9 for exactly 1 cycle.
//  2. 0x12345678+0x9ABCDEF0, carry_i=1 -> sum_o=0xACF13569, carry_o=0.
//  3. Backpressure: ready_i=0 for 5 cycles after valid_o rises.
//     Required: valid_o, sum_o, carry_o stable throughout; IDLE one cycle after ready_i=1.
//  4. start_i pulsed with new operands during RUN and DONE.
//     Required: ready_o=0; the first result is unaffected; no second result appears.
//  5. rst_ni low at RUN cycle 4 -> all outputs are reset values asynchronously.
//     A new op after release: 0x0000000F+0x00000001 gives 0x00000010, carry_o=0.
//  6. Random regression, WIDTH=32 and WIDTH=4 builds, 1000 ops, random ready_i.
//     Required: {carry_o,sum_o} == a+b+carry_i for every op, checked against a model.

Source files
------------

// File: rtl/serial_slice_adder_ctrl.sv
// Serial WIDTH-bit adder that reuses one SLICE-bit adder slice.
// It steps from LSB to MSB, one slice per cycle, with valid/ready on both sides.
module serial_slice_adder_ctrl #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             busy_o
);
    localparam int SL = (SLICE < 1) ? 1 : SLICE;
    localparam int N  = (WIDTH / SL < 1) ? 1 : WIDTH / SL;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((SLICE < 1) || (WIDTH % SL != 0)) begin : g_bad_param
            $error("WIDTH must be a multiple of SLICE and SLICE >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic            r_cy;
    logic            r_carry;
    logic [IW-1:0]   r_idx;
    logic [SL-1:0]   w_sa;
    logic [SL-1:0]   w_sb;
    logic [SL:0]     w_slice;
    logic            w_last;
    logic            w_ready;
    logic            w_valid;
    logic            w_busy;

    assign w_last = (r_idx == IW'(N - 1));

    // Select the operand slice addressed by the current index
    always_comb begin
        w_sa = '0;
        w_sb = '0;
        for (int k = 0; k < N; k++) begin
            if (r_idx == IW'(k)) begin
                w_sa = r_a[k*SL +: SL];
                w_sb = r_b[k*SL +: SL];
            end
        end
    end

    // The shared slice adder: {co, s} = a + b + ci
    assign w_slice = {1'b0, w_sa} + {1'b0, w_sb} + (SL+1)'(r_cy);

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_valid = 1'b0;
        w_busy  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (start_i) w_next = S_RUN;
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                w_busy  = 1'b1;
                w_valid = 1'b1;
                if (ready_i) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operand capture, slice stepping and result accumulation
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cy    <= 1'b0;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_a   <= a_i;
                        r_b   <= b_i;
                        r_cy  <= carry_i;
                        r_idx <= '0;
                    end
                end
                S_RUN: begin
                    r_cy <= w_slice[SL];
                    for (int k = 0; k < N; k++) begin
                        if (r_idx == IW'(k)) begin
                            r_sum[k*SL +: SL] <= w_slice[SL-1:0];
                        end
                    end
                    if (w_last) begin
                        r_carry <= w_slice[SL];
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ready_o = w_ready;
    assign valid_o = w_valid;
    assign busy_o  = w_busy;
    assign sum_o   = r_sum;
    assign carry_o = r_carry;

endmodule

// File: tb/tb_serial_slice_adder_ctrl.sv
// Directed table plus multi-cycle sequences for the serial slice adder.
// A second instance covers the WIDTH==SLICE single-step build.
module tb_serial_slice_adder_ctrl;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, rdy, cin;
    logic        ready_o, valid, cout, busy;
    logic [31:0] a, b, sum;

    logic        q_start, q_rdy, q_cin;
    logic        q_ready_o, q_valid, q_cout, q_busy;
    logic [3:0]  q_a, q_b, q_sum;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_slice_adder_ctrl #(.WIDTH(32), .SLICE(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .ready_o(ready_o),
        .a_i(a), .b_i(b), .carry_i(cin), .valid_o(valid), .ready_i(rdy),
        .sum_o(sum), .carry_o(cout), .busy_o(busy)
    );

    serial_slice_adder_ctrl #(.WIDTH(4), .SLICE(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(q_start), .ready_o(q_ready_o),
        .a_i(q_a), .b_i(q_b), .carry_i(q_cin), .valid_o(q_valid),
        .ready_i(q_rdy), .sum_o(q_sum), .carry_o(q_cout), .busy_o(q_busy)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic [31:0] s;
        logic        co;
    } vec_t;

    vec_t tv[8];

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Issue one op from IDLE; returns the negedge sample index where valid rose.
    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                          input logic ic, output int lat);
        @(negedge clk);
        a = ia; b = ib; cin = ic; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~ia; b = $urandom; cin = ~ic;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!valid && lat < 40);
    endtask

    initial begin
        int lat;
        int k;
        bit ok;
        bit done;
        logic [31:0] ea, eb;
        logic        ec;
        logic [32:0] ex;
        logic [4:0]  qx;

        tv[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
        tv[1] = '{32'h12345678, 32'h9ABCDEF0, 1'b1, 32'hACF13569, 1'b0};
        tv[2] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
        tv[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
        tv[4] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
        tv[5] = '{32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0};
        tv[6] = '{32'h0F0F0F0F, 32'hF0F0F0F0, 1'b0, 32'hFFFFFFFF, 1'b0};
        tv[7] = '{32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1, 32'h00000000, 1'b1};

        rst_n = 1'b0;
        start = 1'b0; rdy = 1'b1; cin = 1'b0; a = '0; b = '0;
        q_start = 1'b0; q_rdy = 1'b1; q_cin = 1'b0; q_a = '0; q_b = '0;
        repeat (2) @(negedge clk);
        check("reset_32", {ready_o, valid, busy, cout, sum},
              {1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
        check("reset_4", {q_ready_o, q_valid, q_busy, q_cout, q_sum},
              {1'b1, 1'b0, 1'b0, 1'b0, 4'h0});
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(tv[i].a, tv[i].b, tv[i].ci, lat);
            check($sformatf("vec%0d_sum", i), sum, tv[i].s);
            check($sformatf("vec%0d_co", i), cout, tv[i].co);
            check($sformatf("vec%0d_lat", i), lat, N + 1);
            @(negedge clk);
            check($sformatf("vec%0d_one_cycle", i), {valid, ready_o},
                  2'b01);
        end

        rdy = 1'b0;
        run_op(32'h12345678, 32'h9ABCDEF0, 1'b1, lat);
        check("bp_lat", lat, N + 1);
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if ({valid, cout, sum} !== {1'b1, 1'b0, 32'hACF13569}) ok = 1'b0;
        end
        check("bp_stable", ok, 1'b1);
        rdy = 1'b1;
        @(negedge clk);
        check("bp_release", {valid, ready_o, busy}, 3'b010);

        rdy = 1'b0;
        @(negedge clk);
        a = 32'h00000003; b = 32'h00000004; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 32'hDEADBEEF; b = 32'h11111111; cin = 1'b1; start = 1'b1;
        check("busy_run_ready", {ready_o, busy}, 2'b01);
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        start = 1'b1; a = 32'hCAFEF00D;
        check("busy_done_ready", {ready_o, valid}, 2'b01);
        @(negedge clk);
        start = 1'b0;
        check("busy_result", {valid, cout, sum}, {1'b1, 1'b0, 32'h7});
        rdy = 1'b1;
        @(negedge clk);
        ok = 1'b1;
        repeat (N + 3) begin
            if (valid || busy) ok = 1'b0;
            @(negedge clk);
        end
        check("busy_no_second", ok, 1'b1);

        @(negedge clk);
        a = 32'h11111111; b = 32'h11111111; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {ready_o, valid, busy, cout, sum},
              {1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'h0000000F, 32'h00000001, 1'b0, lat);
        check("post_reset", {cout, sum}, {1'b0, 32'h00000010});
        @(negedge clk);

        @(negedge clk);
        q_a = 4'hF; q_b = 4'h1; q_cin = 1'b0; q_start = 1'b1;
        @(posedge clk);
        #1;
        q_start = 1'b0; q_a = 4'h0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!q_valid && lat < 40);
        check("n1_lat", lat, 2);
        check("n1_result", {q_cout, q_sum}, 5'h10);
        @(negedge clk);

        for (int i = 0; i < 1000; i++) begin
            ea = $urandom; eb = $urandom; ec = 1'($urandom_range(0, 1));
            ex = {1'b0, ea} + {1'b0, eb} + {32'b0, ec};
            @(negedge clk);
            a = ea; b = eb; cin = ec; start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0; a = $urandom;
            done = 1'b0;
            k = 0;
            while (!done && k < 100) begin
                @(negedge clk);
                k++;
                rdy = 1'($urandom_range(0, 1));
                if (valid && rdy) begin
                    check("rand32", {cout, sum}, ex);
                    done = 1'b1;
                end
            end
            if (!done) check("rand32_timeout", 0, 1);
        end
        @(negedge clk);
        rdy = 1'b1;

        for (int i = 0; i < 1000; i++) begin
            ea = $urandom; eb = $urandom; ec = 1'($urandom_range(0, 1));
            qx = {1'b0, ea[3:0]} + {1'b0, eb[3:0]} + {4'b0, ec};
            @(negedge clk);
            q_a = ea[3:0]; q_b = eb[3:0]; q_cin = ec; q_start = 1'b1;
            @(posedge clk);
            #1;
            q_start = 1'b0; q_b = ~eb[3:0];
            done = 1'b0;
            k = 0;
            while (!done && k < 100) begin
                @(negedge clk);
                k++;
                q_rdy = 1'($urandom_range(0, 1));
                if (q_valid && q_rdy) begin
                    check("rand4", {q_cout, q_sum}, qx);
                    done = 1'b1;
                end
            end
            if (!done) check("rand4_timeout", 0, 1);
        end
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
